// File: rtl/if_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INCR      = 32'd4;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_WAIT  = 2'd1,
        IF_HOLD  = 2'd2
    } if_state_e;

    // One fetched word plus its link address (fetch address + 4)
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } if_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Single-entry {inst, addr} buffer that parks a returned word while decode stalls.
module if_hold_buf
    import if_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  logic      take,
    input  logic      flush,
    input  if_entry_t din,
    output logic      full,
    output if_entry_t dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (flush || take) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, feeds the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        inst_valid
);

    if_state_e   state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        drop, drop_nx;
    logic        buf_load, buf_take, buf_flush, buf_full;
    if_entry_t   buf_din, buf_dout;
    logic        dlv;
    if_entry_t   dlv_ent;

    // rst_n gating keeps the request quiet during reset; no other input reaches these
    assign imem_req  = rst_n && (state == IF_FETCH);
    assign imem_addr = pc;

    // pc has already advanced past the outstanding fetch, so it is the link address
    assign buf_din = '{inst: imem_rdata, addr: pc};

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        drop_nx   = drop;
        buf_load  = 1'b0;
        buf_take  = 1'b0;
        buf_flush = 1'b0;
        dlv       = 1'b0;
        dlv_ent   = buf_din;
        if (redirect)
            pc_nx = word_align(redirect_addr);
        case (state)
            IF_FETCH: begin
                if (imem_ready) begin
                    state_nx = IF_WAIT;
                    if (redirect) drop_nx = 1'b1;
                    else          pc_nx   = pc + PC_INCR;
                end
            end
            IF_WAIT: begin
                if (redirect) begin
                    if (imem_rvalid) begin
                        state_nx = IF_FETCH;
                        drop_nx  = 1'b0;
                    end else begin
                        drop_nx  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    drop_nx  = 1'b0;
                    state_nx = IF_FETCH;
                    if (!drop) begin
                        if (stall) begin
                            buf_load = 1'b1;
                            state_nx = IF_HOLD;
                        end else begin
                            dlv = 1'b1;
                        end
                    end
                end
            end
            IF_HOLD: begin
                if (redirect) begin
                    buf_flush = 1'b1;
                    state_nx  = IF_FETCH;
                end else if (!stall && buf_full) begin
                    buf_take = 1'b1;
                    dlv      = 1'b1;
                    dlv_ent  = buf_dout;
                    state_nx = IF_FETCH;
                end
            end
            default: state_nx = IF_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IF_FETCH;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            drop  <= drop_nx;
        end
    end

    // IF/ID register: flush beats stall, stall beats load, otherwise bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst       <= NOP_INST;
            inst_addr  <= ZERO_WORD;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (!stall) begin
            if (dlv) begin
                inst       <= dlv_ent.inst;
                inst_addr  <= dlv_ent.addr;
                inst_valid <= 1'b1;
            end else begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end
        end
    end

    if_hold_buf u_hold_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load),
        .take  (buf_take),
        .flush (buf_flush),
        .din   (buf_din),
        .full  (buf_full),
        .dout  (buf_dout)
    );

endmodule
